mem_responder: RTL and testbench
================================

# mem_responder

Wait-state memory responder for the 8-bit-address / 16-bit-data CPU memory bus. It answers the CPU's memory requests (`memRW`, `memAddress`, `memD`) against a 16-bit word array, using a request/ready handshake and a parameterized number of wait cycles. The array is preloaded by benches via `$readmemh`. It replaces the zero-latency RAM model when the core is exercised against slow memory.

## Interface
- `DEPTH`, default 256: number of words; a power of 2, at most 256.
- `WAIT_CYCLES`, default 2: extra cycles inserted before each response; legal range 0..15.
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst`, input, 1: reset; one clock; reset is asynchronous and active-low.
- `req`, input, 1: access request, level-sensitive.
- `memRW`, input, 1: 1 = write, 0 = read; sampled with `req`.
- `memAddress`, input, 8: word address; sampled with `req`.
- `memD`, input, 16: write data; sampled with `req`.
- `rdata`, output, 16: read data; registered.
- `ready`, output, 1: one-cycle completion pulse; registered.
- `err`, output, 1: out-of-range flag; exists only with `MEM_RANGE_CHK_EN`.

## Operation
- FSM states are `IDLE`, `BUSY` and `RESP`. Reset puts the FSM in `IDLE` and clears `ready`, `rdata`, `err` and the wait counter to 0. Memory contents are not reset.
- **`IDLE`**
  - With `req`=1 at an edge, it captures `memRW`, `memAddress` and `memD`, loads the counter with `WAIT_CYCLES`, and goes to `BUSY`.
  - With `req`=0 it stays in `IDLE`.
- **`BUSY`**
  - If the counter is 0, it performs the access and goes to `RESP`.
  - Otherwise it decrements the counter.
  - Bus inputs are ignored while in `BUSY`; only the captured values are used.
- **Access**
  - A write stores the captured data at the captured address.
  - A read loads `rdata` from the array.
  - `ready` is registered to 1 on the same edge.
- **`RESP`**
  - `ready`=1 for exactly this cycle.
  - With `req`=1 at the next edge, it accepts a new request (back-to-back) and goes to `BUSY`. Otherwise it goes to `IDLE`.
- The requester must deassert `req` by the edge at which `ready` falls; otherwise a new access is started.
- `rdata` holds its value until the next read completes. Writes leave `rdata` unchanged.
- Address mapping: the array index is `memAddress` modulo `DEPTH` (low log2(`DEPTH`) bits) unless range checking is compiled in.
- A read after a write to the same address returns the new data. There is no hazard, because accesses are serialized.

## Timing
- Acceptance edge A is the `IDLE`/`RESP` edge that samples `req`=1.
- `ready` rises at edge A+`WAIT_CYCLES`+1 and falls at A+`WAIT_CYCLES`+2.
- A write commits at edge A+`WAIT_CYCLES`+1. Read data is valid at the same edge as `ready`.
- Throughput is one access per `WAIT_CYCLES`+2 cycles with continuous `req`.
- With `WAIT_CYCLES`=0, `ready` rises one edge after acceptance.
- Reset asserted mid-access:
  - Outputs clear immediately.
  - An uncommitted write is dropped and the array is unchanged.
  - After release, the first edge with `req`=1 starts a fresh access.

## Configuration
- **`MEM_RANGE_CHK_EN` defined:**
  - `memAddress` >= `DEPTH` is an error.
  - On an error, the access is suppressed: no write, and `rdata` is unchanged.
  - `err`=1 is pulsed together with `ready`, so handshake timing is unchanged.
  - `err` resets to 0.
- **`MEM_RANGE_CHK_EN` undefined:**
  - The `err` port and its logic are absent.
  - Addresses wrap modulo `DEPTH`.

## Structure
- Shared package `cpu_pkg` holds:
  - `MEM_AW`=8 and `MEM_DW`=16.
  - The FSM state enum `mem_state_t` (`IDLE`, `BUSY`, `RESP`).
- Sub-module `mem_array` holds the storage:
  - Array `MEM[0:DEPTH-1]` of 16-bit words.
  - Synchronous write enable and a registered read port.
  - Bench preload path is `<dut>.u_arr.MEM`.
- The top level holds the FSM, the counter, the capture registers and the range check.

## Test plan
- Preload `MEM[0x05]`=`16'h1234`, `WAIT_CYCLES`=2, read 0x05 → `ready` pulses at A+3 for one cycle, `rdata`=`16'h1234`.
- Write `16'h00AA` to 0x0F, then read 0x0F back-to-back with `req` held → second `ready` at A+7, `rdata`=`16'h00AA`.
- `WAIT_CYCLES`=0, four consecutive reads of 0x00..0x03 with `req` held → `ready` every 2nd cycle, data in order.
- Start a write of `16'hBEEF` to 0x20, drop `rst` at A+1 → `ready`/`rdata`=0 immediately, `MEM[0x20]` unchanged, next read works.
- `DEPTH`=16, read 0x13:
  - Without the macro → returns `MEM[0x3]`.
  - With `MEM_RANGE_CHK_EN` → `err`=1 with `ready`, `rdata` unchanged.
- Change `memAddress`/`memD` during `BUSY` → the access uses the captured values only.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU memory-bus definitions: bus widths and the memory responder FSM states.
package cpu_pkg;

   localparam int MEM_AW = 8;
   localparam int MEM_DW = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } mem_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory bus with request/ready handshake; err only exists when MEM_RANGE_CHK_EN is defined.
interface mem_responder_if;
   import cpu_pkg::*;

   logic              req;
   logic              memRW;
   logic [MEM_AW-1:0] memAddress;
   logic [MEM_DW-1:0] memD;
   logic [MEM_DW-1:0] rdata;
   logic              ready;
`ifdef MEM_RANGE_CHK_EN
   logic              err;
`endif

`ifdef MEM_RANGE_CHK_EN
   modport master (output req, memRW, memAddress, memD, input rdata, ready, err);
   modport slave  (input req, memRW, memAddress, memD, output rdata, ready, err);
`else
   modport master (output req, memRW, memAddress, memD, input rdata, ready);
   modport slave  (input req, memRW, memAddress, memD, output rdata, ready);
`endif

endinterface

// File: rtl/mem_array.sv
// Word storage for mem_responder: synchronous write, registered read port.
// Only the read register is reset; the array contents survive reset.
module mem_array
   import cpu_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [AW-1:0]     addr,
   input  logic [MEM_DW-1:0] wdata,
   output logic [MEM_DW-1:0] rdata
);

   logic [MEM_DW-1:0] MEM [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         MEM[addr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= MEM[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: captures a request, waits WAIT_CYCLES, then performs it and pulses ready.
// Optional MEM_RANGE_CHK_EN suppresses out-of-range accesses and flags them on err.
module mem_responder
   import cpu_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input logic            clk,
   input logic            rst,
   mem_responder_if.slave bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   mem_state_t        state, state_next;
   logic [3:0]        cnt, cnt_next;
   logic              cap_rw;
   logic [MEM_AW-1:0] cap_addr;
   logic [MEM_DW-1:0] cap_data;
   logic              accept;
   logic              access;
   logic              in_range;
   logic              ready_q;
   logic [MEM_DW-1:0] rd_data;

   // Bus inputs are only looked at when a new request can be accepted (IDLE or RESP).
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept     = 1'b0;
      access     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req) begin
               accept     = 1'b1;
               state_next = BUSY;
               cnt_next   = 4'(WAIT_CYCLES);
            end
         end
         BUSY: begin
            if (cnt == 4'd0) begin
               access     = 1'b1;
               state_next = RESP;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         RESP: begin
            if (bus.req) begin
               accept     = 1'b1;
               state_next = BUSY;
               cnt_next   = 4'(WAIT_CYCLES);
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         cap_rw   <= 1'b0;
         cap_addr <= '0;
         cap_data <= '0;
         ready_q  <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         ready_q <= access;
         if (accept) begin
            cap_rw   <= bus.memRW;
            cap_addr <= bus.memAddress;
            cap_data <= bus.memD;
         end
      end
   end

`ifdef MEM_RANGE_CHK_EN
   logic err_q;

   assign in_range = ({1'b0, cap_addr} < 9'(DEPTH));

   // err rides alongside ready so the handshake timing is the same for bad addresses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= access & ~in_range;
      end
   end

   assign bus.err = err_q;
`else
   assign in_range = 1'b1;
`endif

   mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_arr (
      .clk   (clk),
      .rst   (rst),
      .we    (access & cap_rw & in_range),
      .re    (access & ~cap_rw & in_range),
      .addr  (cap_addr[AW-1:0]),
      .wdata (cap_data),
      .rdata (rd_data)
   );

   assign bus.rdata = rd_data;
   assign bus.ready = ready_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_CYCLES=2/DEPTH=256 and WAIT_CYCLES=0/DEPTH=16)
// driven from a vector table, responses checked against a scoreboard of expected data and ready edges.
module tb_mem_responder;

   typedef struct {
      int          sel;
      logic        rw;
      logic [7:0]  addr;
      logic [15:0] data;
      logic [15:0] expRdata;
      logic        expErr;
      logic        chain;
   } vec_t;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          edgeN;
   } exp_t;

   localparam int NV = 23;

   logic clk;
   logic rst;
   int   cyc;
   int   tests;
   int   fails;
   vec_t vecs [NV];
   exp_t qA[$];
   exp_t qB[$];
   logic prevA;
   logic prevB;

   mem_responder_if busA ();
   mem_responder_if busB ();

   mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (busA.slave)
   );

   mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dutB (
      .clk (clk),
      .rst (rst),
      .bus (busB.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int waitOf(input int sel);
      return (sel == 0) ? 2 : 0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input int sel, input logic rw, input logic [7:0] addr,
                                input logic [15:0] data, input logic req);
      if (sel == 0) begin
         busA.memRW = rw; busA.memAddress = addr; busA.memD = data; busA.req = req;
      end else begin
         busB.memRW = rw; busB.memAddress = addr; busB.memD = data; busB.req = req;
      end
   endtask

   // Garbage on the bus while BUSY must not leak into the captured access.
   task automatic scramble(input int sel);
      if (sel == 0) begin
         busA.memRW = ~busA.memRW; busA.memAddress = ~busA.memAddress; busA.memD = ~busA.memD;
      end else begin
         busB.memRW = ~busB.memRW; busB.memAddress = ~busB.memAddress; busB.memD = ~busB.memD;
      end
   endtask

   task automatic runTable(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         exp_t e;
         bit   seen;
         applyStimulus(vecs[i].sel, vecs[i].rw, vecs[i].addr, vecs[i].data, 1'b1);
         @(posedge clk); #1;
         e.rdata = vecs[i].expRdata;
         e.err   = vecs[i].expErr;
         e.edgeN = cyc + waitOf(vecs[i].sel) + 1;
         if (vecs[i].sel == 0) qA.push_back(e); else qB.push_back(e);
         scramble(vecs[i].sel);
         if (!vecs[i].chain) begin
            if (vecs[i].sel == 0) busA.req = 1'b0; else busB.req = 1'b0;
         end
         seen = 1'b0;
         for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = (vecs[i].sel == 0) ? busA.ready : busB.ready;
         end
         if (!seen) begin
            fails++;
            $display("[TB] FAIL timeout vec %0d: ready never rose", i);
         end
         if (!vecs[i].chain) begin
            @(posedge clk); #1;
         end
      end
   endtask

   // Scoreboard monitors: every ready pulse pops one expected response.
   always @(negedge clk) begin
      if (busA.ready) begin
         checkOutput("A_singlePulse", 32'(prevA), 32'd0);
         if (qA.size() == 0) begin
            checkOutput("A_unexpectedReady", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = qA.pop_front();
            checkOutput("A_rdata", 32'(busA.rdata), 32'(e.rdata));
            checkOutput("A_readyEdge", 32'(cyc), 32'(e.edgeN));
`ifdef MEM_RANGE_CHK_EN
            checkOutput("A_err", 32'(busA.err), 32'(e.err));
`endif
         end
      end
      prevA <= busA.ready;
   end

   always @(negedge clk) begin
      if (busB.ready) begin
         checkOutput("B_singlePulse", 32'(prevB), 32'd0);
         if (qB.size() == 0) begin
            checkOutput("B_unexpectedReady", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = qB.pop_front();
            checkOutput("B_rdata", 32'(busB.rdata), 32'(e.rdata));
            checkOutput("B_readyEdge", 32'(cyc), 32'(e.edgeN));
`ifdef MEM_RANGE_CHK_EN
            checkOutput("B_err", 32'(busB.err), 32'(e.err));
`endif
         end
      end
      prevB <= busB.ready;
   end

   initial begin
      tests = 0;
      fails = 0;
      cyc   = 0;
      prevA = 1'b0;
      prevB = 1'b0;

      // sel, rw, addr, data, expected rdata, expected err, back-to-back with next
      vecs[0]  = '{0, 1'b1, 8'h05, 16'h1234, 16'h0000, 1'b0, 1'b0};
      vecs[1]  = '{0, 1'b0, 8'h05, 16'h0000, 16'h1234, 1'b0, 1'b0};
      vecs[2]  = '{0, 1'b1, 8'h0F, 16'h00AA, 16'h1234, 1'b0, 1'b1};
      vecs[3]  = '{0, 1'b0, 8'h0F, 16'h0000, 16'h00AA, 1'b0, 1'b0};
      vecs[4]  = '{0, 1'b1, 8'h20, 16'h5555, 16'h00AA, 1'b0, 1'b0};
      vecs[5]  = '{0, 1'b1, 8'h30, 16'h7777, 16'h00AA, 1'b0, 1'b1};
      vecs[6]  = '{0, 1'b0, 8'h05, 16'h0000, 16'h1234, 1'b0, 1'b1};
      vecs[7]  = '{0, 1'b0, 8'h30, 16'h0000, 16'h7777, 1'b0, 1'b0};
      vecs[8]  = '{1, 1'b1, 8'h00, 16'h1111, 16'h0000, 1'b0, 1'b1};
      vecs[9]  = '{1, 1'b1, 8'h01, 16'h2222, 16'h0000, 1'b0, 1'b1};
      vecs[10] = '{1, 1'b1, 8'h02, 16'h3333, 16'h0000, 1'b0, 1'b1};
      vecs[11] = '{1, 1'b1, 8'h03, 16'h4444, 16'h0000, 1'b0, 1'b0};
      vecs[12] = '{1, 1'b0, 8'h00, 16'h0000, 16'h1111, 1'b0, 1'b1};
      vecs[13] = '{1, 1'b0, 8'h01, 16'h0000, 16'h2222, 1'b0, 1'b1};
      vecs[14] = '{1, 1'b0, 8'h02, 16'h0000, 16'h3333, 1'b0, 1'b1};
      vecs[15] = '{1, 1'b0, 8'h03, 16'h0000, 16'h4444, 1'b0, 1'b0};
      vecs[16] = '{1, 1'b0, 8'h01, 16'h0000, 16'h2222, 1'b0, 1'b0};
`ifdef MEM_RANGE_CHK_EN
      vecs[17] = '{1, 1'b0, 8'h13, 16'h0000, 16'h2222, 1'b1, 1'b0};
      vecs[18] = '{1, 1'b1, 8'h13, 16'hAAAA, 16'h2222, 1'b1, 1'b0};
      vecs[19] = '{1, 1'b0, 8'h03, 16'h0000, 16'h4444, 1'b0, 1'b0};
`else
      vecs[17] = '{1, 1'b0, 8'h13, 16'h0000, 16'h4444, 1'b0, 1'b0};
      vecs[18] = '{1, 1'b1, 8'h13, 16'hAAAA, 16'h4444, 1'b0, 1'b0};
      vecs[19] = '{1, 1'b0, 8'h03, 16'h0000, 16'hAAAA, 1'b0, 1'b0};
`endif
      vecs[20] = '{0, 1'b0, 8'h20, 16'h0000, 16'h5555, 1'b0, 1'b0};
      vecs[21] = '{0, 1'b0, 8'h0F, 16'h0000, 16'h00AA, 1'b0, 1'b0};
      vecs[22] = '{1, 1'b0, 8'h02, 16'h0000, 16'h3333, 1'b0, 1'b0};

      rst = 1'b0;
      applyStimulus(0, 1'b0, 8'h00, 16'h0000, 1'b0);
      applyStimulus(1, 1'b0, 8'h00, 16'h0000, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("reset_A_ready", 32'(busA.ready), 32'd0);
      checkOutput("reset_A_rdata", 32'(busA.rdata), 32'd0);
      checkOutput("reset_B_ready", 32'(busB.ready), 32'd0);
      checkOutput("reset_B_rdata", 32'(busB.rdata), 32'd0);
`ifdef MEM_RANGE_CHK_EN
      checkOutput("reset_A_err", 32'(busA.err), 32'd0);
`endif

      runTable(0, 19);

      // Reset one edge into a write: the write must be dropped and outputs cleared at once.
      applyStimulus(0, 1'b1, 8'h20, 16'hBEEF, 1'b1);
      @(posedge clk); #1;
      busA.req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checkOutput("midRst_A_ready", 32'(busA.ready), 32'd0);
      checkOutput("midRst_A_rdata", 32'(busA.rdata), 32'd0);
      checkOutput("midRst_B_rdata", 32'(busB.rdata), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("postRst_A_ready", 32'(busA.ready), 32'd0);
      end

      runTable(20, 22);

      repeat (4) @(posedge clk);
      checkOutput("A_queueEmpty", 32'(qA.size()), 32'd0);
      checkOutput("B_queueEmpty", 32'(qB.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
